// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serial link (transmitter and receiver).
package nibble_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int width, input int parity_en);
    return width + 2 + parity_en;
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Word handshake between a parallel source and the serializer.
interface nibble_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d_in;
  logic             d_valid;
  logic             d_ready;

  modport master (output d_in, output d_valid, input d_ready);
  modport slave  (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/nibble_serializer_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, pulses o_tick on the wrap cycle.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  output logic          o_tick,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign o_cnt  = r_cnt;

  // Free-running divider; a clear restarts the phase at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial UART-style transmitter: start, data LSB first,
// optional even parity, stop.
module nibble_serializer
  import nibble_link_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1,
  localparam int BCW = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  nibble_serializer_if.slave  s_if,
  output logic                tx,
  output logic                busy,
  output logic                done
);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BCW-1:0]   r_bitcnt;
  logic             r_par;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
  logic             w_xfer;
  logic             w_tick;
  logic [CW-1:0]    w_cnt;

  // d_ready is only high in IDLE, so this is a transfer out of IDLE.
  assign w_xfer     = s_if.d_valid & r_ready;
  assign s_if.d_ready = r_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_xfer),
    .o_tick (w_tick),
    .o_cnt  (w_cnt)
  );

  // Frame sequencer. tx/busy/done/ready are registered; done is raised on
  // the edge that enters the final STOP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_tx     <= TX_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer) begin
          r_state <= START;
          r_tx    <= START_BIT;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
          r_shreg <= s_if.d_in;
          r_par   <= ^s_if.d_in;
        end
        // The bit on the line is shifted out of r_shreg as it is launched.
        START: if (w_tick) begin
          r_state  <= DATA;
          r_tx     <= r_shreg[0];
          r_shreg  <= r_shreg >> 1;
          r_bitcnt <= '0;
        end
        DATA: if (w_tick) begin
          if (r_bitcnt == BCW'(WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              r_state <= PARITY;
              r_tx    <= r_par;
            end else begin
              r_state <= STOP;
              r_tx    <= STOP_BIT;
              r_done  <= (CLKS_PER_BIT == 1);
            end
          end else begin
            r_tx     <= r_shreg[0];
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        PARITY: if (w_tick) begin
          r_state <= STOP;
          r_tx    <= STOP_BIT;
          r_done  <= (CLKS_PER_BIT == 1);
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= TX_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_done <= (int'(w_cnt) == CLKS_PER_BIT - 2);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: DUT A (4 clk/bit, parity) and DUT B
// (1 clk/bit, no parity). A negedge monitor checks every frame cycle
// against frames queued by the drivers.
module tb_nibble_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  nibble_serializer_if #(.WIDTH(4)) if_a ();
  nibble_serializer_if #(.WIDTH(4)) if_b ();

  nibble_serializer #(.WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .s_if(if_a.slave), .tx(tx_a), .busy(busy_a), .done(done_a));
  nibble_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .s_if(if_b.slave), .tx(tx_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Scoreboard: bit i of a frame vector is the i-th bit on the line.
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];
  bit         act[2];
  int         idx[2];
  logic [6:0] cur[2];
  int         xfers[2];
  int         dones[2];
  int         gap[2];
  int         last_done[2];
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic tv, bv, dv, rv, vv;
      int   cpb, len;
      tv  = (k == 0) ? tx_a : tx_b;
      bv  = (k == 0) ? busy_a : busy_b;
      dv  = (k == 0) ? done_a : done_b;
      rv  = (k == 0) ? if_a.d_ready : if_b.d_ready;
      vv  = (k == 0) ? if_a.d_valid : if_b.d_valid;
      cpb = (k == 0) ? 4 : 1;
      len = (k == 0) ? 28 : 6;
      if (!reset) begin
        act[k] = 1'b0;
      end else begin
        if (act[k]) begin
          chk($sformatf("tx[%0d] idx%0d", k, idx[k]), tv, cur[k][idx[k] / cpb]);
          chk($sformatf("busy[%0d] idx%0d", k, idx[k]), bv, 1'b1);
          chk($sformatf("ready[%0d] idx%0d", k, idx[k]), rv, 1'b0);
          chk($sformatf("done[%0d] idx%0d", k, idx[k]), dv, (idx[k] == len - 1));
          idx[k]++;
          if (idx[k] == len) begin
            act[k] = 1'b0;
            last_done[k] = cyc;
          end
        end else begin
          chk($sformatf("idle_tx[%0d]", k), tv, 1'b1);
          chk($sformatf("idle_busy[%0d]", k), bv, 1'b0);
          chk($sformatf("idle_done[%0d]", k), dv, 1'b0);
        end
        if (dv) dones[k]++;
        if (vv && rv) begin
          xfers[k]++;
          if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
            chk($sformatf("unexpected_xfer[%0d]", k), 1, 0);
          end else begin
            cur[k] = (k == 0) ? q_a.pop_front() : q_b.pop_front();
            act[k] = 1'b1;
            idx[k] = 0;
            gap[k] = cyc + 1 - last_done[k];
          end
        end
      end
    end
  end

  task automatic drive(input int k, input logic v, input logic [3:0] d);
    if (k == 0) begin if_a.d_valid = v; if_a.d_in = d; end
    else        begin if_b.d_valid = v; if_b.d_in = d; end
  endtask

  // Wait (bounded) for ready at a negedge; the next posedge is the transfer.
  task automatic wait_ready(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((k == 0) ? if_a.d_ready : if_b.d_ready) && n < 200);
    if (n >= 200) chk($sformatf("ready_timeout[%0d]", k), 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int k, input logic [3:0] d, input logic [6:0] fr);
    if (k == 0) q_a.push_back(fr); else q_b.push_back(fr);
    drive(k, 1'b1, d);
    wait_ready(k);
    drive(k, 1'b0, d);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(!act[k] && ((k == 0) ? if_a.d_ready : if_b.d_ready)) && n < 300);
    if (n >= 300) chk($sformatf("idle_timeout[%0d]", k), 0, 1);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [6:0] fa;
    logic [5:0] fb;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int x0, d0;
    tbl[0] = '{4'b1010, 7'b1010100, 6'b110100};
    tbl[1] = '{4'b1111, 7'b1011110, 6'b111110};
    tbl[2] = '{4'b0000, 7'b1000000, 6'b100000};
    tbl[3] = '{4'b1000, 7'b1110000, 6'b110000};
    drive(0, 1'b1, 4'b1010);
    drive(1, 1'b0, 4'b0000);

    // Reset held with d_valid high: line idle, ready, not busy.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_ready", if_a.d_ready, 1'b1);
      chk("rst_busy", busy_a, 1'b0);
    end
    chk("rst_no_xfer", xfers[0], 0);
    reset = 1'b1;
    send(0, 4'b1010, 7'b1010100);
    wait_idle(0);
    chk("first_xfer_count", xfers[0], 1);
    chk("first_done_count", dones[0], 1);

    // Table: each word on both configurations.
    for (int i = 0; i < 4; i++) begin
      send(0, tbl[i].d, tbl[i].fa);
      wait_idle(0);
      send(1, tbl[i].d, {1'b0, tbl[i].fb});
      wait_idle(1);
    end

    // Back-to-back with d_valid held high.
    x0 = xfers[0]; d0 = dones[0];
    q_a.push_back(7'b1101110);
    q_a.push_back(7'b1000110);
    drive(0, 1'b1, 4'b0111);
    wait_ready(0);
    drive(0, 1'b1, 4'b0011);
    wait_ready(0);
    drive(0, 1'b0, 4'b0011);
    chk("b2b_gap", gap[0], 2);
    wait_idle(0);
    chk("b2b_xfers", xfers[0] - x0, 2);
    chk("b2b_dones", dones[0] - d0, 2);

    // Reset in the DATA bit-2 period, then a clean frame.
    d0 = dones[0];
    send(0, 4'b0001, 7'b1100010);
    repeat (13) @(posedge clk);
    #1;
    chk("pre_abort_tx", tx_a, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx_a, 1'b1);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ready", if_a.d_ready, 1'b1);
    chk("abort_done", done_a, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_no_done", dones[0] - d0, 0);
    send(0, 4'b0100, 7'b1101000);
    wait_idle(0);
    chk("post_abort_done", dones[0] - d0, 1);

    // d_valid / d_in wiggled while busy: captured word goes out unchanged.
    x0 = xfers[0];
    send(0, 4'b0010, 7'b1100100);
    repeat (5) @(posedge clk);
    #1; drive(0, 1'b1, 4'b0100);
    repeat (3) @(posedge clk);
    #1; drive(0, 1'b0, 4'b0100);
    repeat (4) @(posedge clk);
    #1; drive(0, 1'b1, 4'b0100);
    repeat (3) @(posedge clk);
    #1; drive(0, 1'b0, 4'b0100);
    wait_idle(0);
    chk("midframe_xfers", xfers[0] - x0, 1);
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
